// File: rtl/channel_write_scheduler_if.sv
// rtl/channel_write_scheduler_if.sv - requester/channel-table bundle for channel_write_scheduler
interface channel_write_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [6*NREQ-1:0]  req_addr;
    logic [11*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [10:0]        data;
    logic [5:0]         dataChange;
    logic               busy;
    logic [2:0]         grant_id;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, data, dataChange, busy, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, data, dataChange, busy, grant_id
    );
endinterface

// File: rtl/channel_write_scheduler.sv
// rtl/channel_write_scheduler.sv - round-robin sequencer for the 64x11 channel table write port
// Optional duplicate-write suppression enabled by defining CWS_SKIP_DUP_EN.
module channel_write_scheduler #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    channel_write_scheduler_if.slave bus
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_hold_cnt;
    logic [2:0]     r_rr_ptr;
    logic [2:0]     r_grant_id;
    logic [10:0]    r_data;
    logic [5:0]     r_addr;
    logic           r_busy;

    logic [7:0]     w_valid_ext;
    logic [5:0]     w_addr_arr [8];
    logic [10:0]    w_data_arr [8];
    logic           w_found;
    logic [2:0]     w_gnt;
    logic [5:0]     w_sel_addr;
    logic [10:0]    w_sel_data;
    logic           w_dup;
    logic [NREQ-1:0] w_ready;

    // Requester lanes padded to 8 so the 3-bit grant index is always in range.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        if (gi < NREQ) begin : g_on
            assign w_valid_ext[gi] = bus.req_valid[gi];
            assign w_addr_arr[gi]  = bus.req_addr[6*gi +: 6];
            assign w_data_arr[gi]  = bus.req_data[11*gi +: 11];
        end else begin : g_off
            assign w_valid_ext[gi] = 1'b0;
            assign w_addr_arr[gi]  = '0;
            assign w_data_arr[gi]  = '0;
        end
    end

    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return 3'(s);
    endfunction

    // Scan farthest-first so the nearest valid index after rr_ptr is the one kept.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (w_valid_ext[wrap_idx(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_gnt   = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_sel_addr = w_addr_arr[w_gnt];
    assign w_sel_data = w_data_arr[w_gnt];

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = (r_state == S_IDLE) && w_found && (w_gnt == 3'(i));
        end
    end

`ifdef CWS_SKIP_DUP_EN
    logic [10:0] r_shadow [64];
    logic [63:0] r_shadow_vld;

    assign w_dup = r_shadow_vld[w_sel_addr] && (r_shadow[w_sel_addr] == w_sel_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_vld <= '0;
        end else if (r_state == S_IDLE && w_found && !w_dup) begin
            r_shadow_vld[w_sel_addr] <= 1'b1;
            r_shadow[w_sel_addr]     <= w_sel_data;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_rr_ptr   <= 3'(NREQ - 1);
            r_grant_id <= '0;
            r_data     <= '0;
            r_addr     <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_rr_ptr <= w_gnt;
                        // A suppressed duplicate is acknowledged but never reaches the table.
                        if (!w_dup) begin
                            r_data     <= w_sel_data;
                            r_addr     <= w_sel_addr;
                            r_grant_id <= w_gnt;
                            r_busy     <= 1'b1;
                            r_hold_cnt <= '0;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == LAST_CNT) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.data       = r_data;
    assign bus.dataChange = r_addr;
    assign bus.busy       = r_busy;
    assign bus.grant_id   = r_grant_id;

endmodule

// File: tb/tb_channel_write_scheduler.sv
// tb/tb_channel_write_scheduler.sv - directed self-checking bench for channel_write_scheduler
module tb_channel_write_scheduler;
    localparam int NREQ = 4;
    localparam int HOLD = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    channel_write_scheduler_if #(.NREQ(NREQ)) bus();

    channel_write_scheduler #(
        .NREQ(NREQ),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [5:0] a, input logic [10:0] d);
        bus.req_valid[i]         = v;
        bus.req_addr[6*i +: 6]   = a;
        bus.req_data[11*i +: 11] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req_valid = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output logic [3:0] rdy);
        rdy = '0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.req_ready != '0) begin
                rdy = bus.req_ready;
                return;
            end
            @(negedge clk);
        end
        check({tag, "_timeout"}, 32'(bus.req_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] rdy;
        logic [3:0] go [5];
        int         gt [5];
        int         ng;
        int         bc;
        int         t0;
        int         exp_dup_busy;

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < 5; i++) begin
            go[i] = '0;
            gt[i] = 0;
        end

        // Reset, then idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("rst_data", 32'(bus.data), 32'h0);
        check("rst_addr", 32'(bus.dataChange), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_gid", 32'(bus.grant_id), 32'h0);

        // Single request, hold window length
        @(negedge clk);
        set_req(0, 1'b1, 6'd5, 11'h3FF);
        wait_ready("t2_ready", rdy);
        check("t2_ready", 32'(rdy), 32'h1);
        @(negedge clk);
        #1;
        check("t2_ready_pulse", 32'(bus.req_ready), 32'h0);
        check("t2_data", 32'(bus.data), 32'h3FF);
        check("t2_addr", 32'(bus.dataChange), 32'h5);
        check("t2_gid", 32'(bus.grant_id), 32'h0);
        set_req(0, 1'b0, 6'd0, 11'h0);
        bc = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.busy) bc++;
            @(negedge clk);
            #1;
        end
        check("t2_busy_cycles", 32'(bc), 32'd11);

        // Saturation: round-robin order and spacing
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 6'(i + 1), 11'(16 * i + 1));
        ng = 0;
        for (int n = 0; n < 70; n++) begin
            #1;
            if (bus.req_ready != '0 && ng < 5) begin
                go[ng] = bus.req_ready;
                gt[ng] = cyc;
                ng++;
            end
            @(negedge clk);
        end
        check("t3_g0", 32'(go[0]), 32'h1);
        check("t3_g1", 32'(go[1]), 32'h2);
        check("t3_g2", 32'(go[2]), 32'h4);
        check("t3_g3", 32'(go[3]), 32'h8);
        check("t3_g4", 32'(go[4]), 32'h1);
        for (int i = 1; i < 5; i++) check("t3_spacing", 32'(gt[i] - gt[i-1]), 32'd12);
        bus.req_valid = '0;

        // Same slot from req1 then req3
        do_reset();
        set_req(1, 1'b1, 6'd10, 11'h111);
        set_req(3, 1'b1, 6'd10, 11'h222);
        wait_ready("t4_first", rdy);
        check("t4_first", 32'(rdy), 32'h2);
        t0 = cyc;
        @(negedge clk);
        set_req(1, 1'b0, 6'd0, 11'h0);
        #1;
        check("t4_data1", 32'(bus.data), 32'h111);
        check("t4_addr1", 32'(bus.dataChange), 32'd10);
        check("t4_gid1", 32'(bus.grant_id), 32'd1);
        wait_ready("t4_second", rdy);
        check("t4_second", 32'(rdy), 32'h8);
        check("t4_hold_len", 32'(cyc - t0), 32'd12);
        @(negedge clk);
        set_req(3, 1'b0, 6'd0, 11'h0);
        #1;
        check("t4_data2", 32'(bus.data), 32'h222);
        check("t4_addr2", 32'(bus.dataChange), 32'd10);
        check("t4_gid2", 32'(bus.grant_id), 32'd3);

        // Reset in the middle of a hold window
        do_reset();
        set_req(0, 1'b1, 6'd20, 11'h0AA);
        wait_ready("t5_grant", rdy);
        check("t5_grant", 32'(rdy), 32'h1);
        @(negedge clk);
        set_req(0, 1'b1, 6'd21, 11'h0BB);
        set_req(1, 1'b1, 6'd22, 11'h0CC);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_busy", 32'(bus.busy), 32'h0);
        check("t5_data", 32'(bus.data), 32'h0);
        check("t5_addr", 32'(bus.dataChange), 32'h0);
        check("t5_gid", 32'(bus.grant_id), 32'h0);
        check("t5_regrant", 32'(bus.req_ready), 32'h1);

        // Repeated identical write to one slot
        do_reset();
        set_req(0, 1'b1, 6'd7, 11'h055);
        wait_ready("t6_first", rdy);
        check("t6_first", 32'(rdy), 32'h1);
        @(negedge clk);
        set_req(0, 1'b0, 6'd0, 11'h0);
        for (int n = 0; n < 30 && bus.busy; n++) @(negedge clk);
        #1;
        check("t6_idle", 32'(bus.busy), 32'h0);
        @(negedge clk);
        set_req(0, 1'b1, 6'd7, 11'h055);
        wait_ready("t6_second", rdy);
        check("t6_second", 32'(rdy), 32'h1);
        @(negedge clk);
        set_req(0, 1'b0, 6'd0, 11'h0);
`ifdef CWS_SKIP_DUP_EN
        exp_dup_busy = 0;
`else
        exp_dup_busy = 11;
`endif
        bc = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (bus.busy) bc++;
            @(negedge clk);
        end
        check("t6_dup_busy", 32'(bc), 32'(exp_dup_busy));
        check("t6_data", 32'(bus.data), 32'h055);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
